// File: rtl/daq_readout_ctrl.sv
// -----------------------------------------------------------------------------
// daq_readout_ctrl
//
// Trigger-driven ADC capture and byte-serial readout.
//
// When idle and enabled, a trigger latches the capture settings. The block
// waits capture_delay cycles, then writes sample_len consecutive ADC samples
// into a local buffer. It then streams one packet over a valid/ready byte
// interface:
//   byte 0       : {strb, 1'b0, pulse_ctr[5:0]}
//   per sample i : {4'h0, d[11:8]}, then d[7:0]   (sample 0 first)
// A trigger that arrives while busy is dropped and sets a sticky overrun flag.
//
// Ports
//   clk            in   single clock, all registers on posedge
//   rst_b          in   asynchronous active-low reset
//   run            in   enable; low aborts capture or ends readout early
//   trig_out       in   one-cycle trigger pulse
//   trig_strb      in   marks a real-data trigger (coincident with trig_out)
//   pulse_ctr[5:0] in   pulse count, copied into the header byte
//   capture_delay  in   cycles from trigger to first sample
//   sample_len     in   samples per capture (values above DEPTH clamp)
//   adc_data       in   sample bus, sampled every cycle
//   ovr_clr        in   clears overrun (a simultaneous set wins)
//   trig_rdy       out  registered, high exactly while idle
//   tx_data[7:0]   out  readout byte
//   tx_valid       out  tx_data valid
//   tx_ready       in   sink accepts the byte this cycle
//   overrun        out  sticky: trigger seen while busy
// -----------------------------------------------------------------------------
module daq_readout_ctrl #(
  parameter int DATA_W = 12,   // byte packing below assumes exactly 12
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              run,
  input  logic              trig_out,
  input  logic              trig_strb,
  input  logic [5:0]        pulse_ctr,
  input  logic [7:0]        capture_delay,
  input  logic [6:0]        sample_len,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              ovr_clr,
  output logic              trig_rdy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              overrun
);

  localparam int         ADDR_W  = $clog2(DEPTH);
  localparam logic [6:0] MAX_LEN = 7'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    CAPTURE,
    HEADER,
    DRAIN
  } state_t;

  state_t            state;
  logic [7:0]        dly_cnt;     // remaining delay cycles
  logic [6:0]        len_q;       // clamped sample count for this capture
  logic [6:0]        wr_idx;      // capture write index
  logic [6:0]        rd_idx;      // next sample to be read for readout
  logic [7:0]        byte_cnt;    // bytes already transferred in this packet
  logic [5:0]        pulse_q;
  logic              strb_q;
  logic [7:0]        lo_hold;     // low byte of the sample whose high byte is out

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;        // prefetched sample at rd_idx

  logic [6:0]        len_clamped;
  logic [7:0]        last_byte;
  logic              xfer;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  assign len_clamped = (sample_len > MAX_LEN) ? MAX_LEN : sample_len;
  // Byte indices run 0 (header) .. 2*len, so the last index is 2*len.
  assign last_byte   = {len_q, 1'b0};
  assign xfer        = tx_valid & tx_ready;
  assign wr_en       = (state == CAPTURE) & run;
  assign wr_addr     = wr_idx[ADDR_W-1:0];
  // rd_idx steps one past the final sample after its high byte goes out; the
  // wrapped address reads a don't-care value that is never sent.
  assign rd_addr     = rd_idx[ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // Capture buffer
  // ---------------------------------------------------------------------------
  // NOTE: the sample array has no reset branch; resetting a memory turns it
  // into a huge register file and blocks RAM inference, and the contents are
  // always rewritten before they are read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= adc_data;
    end
  end

  // Synchronous read, re-issued every cycle so the next sample is already
  // waiting when the previous sample's low byte is loaded. The write bypass
  // covers a one-sample capture, where sample 0 is written on the very edge
  // that enters HEADER.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_q <= '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_q <= adc_data;
    end else begin
      rd_q <= mem[rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every assignment here is non-blocking, so all right-hand sides see
  // the pre-edge values regardless of statement order; mixing in blocking
  // assignments would make the result depend on that order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      trig_rdy <= 1'b1;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      overrun  <= 1'b0;
      dly_cnt  <= '0;
      len_q    <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      byte_cnt <= '0;
      pulse_q  <= '0;
      strb_q   <= 1'b0;
      lo_hold  <= '0;
    end else begin
      // Set is tested first so a coincident clear loses.
      if (trig_out && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (run && trig_out) begin
            dly_cnt  <= capture_delay;
            len_q    <= len_clamped;
            pulse_q  <= pulse_ctr;
            strb_q   <= trig_strb;
            wr_idx   <= '0;
            rd_idx   <= '0;
            byte_cnt <= '0;
            trig_rdy <= 1'b0;
            if (capture_delay != 8'd0) begin
              state <= DELAY;
            end else if (len_clamped == 7'd0) begin
              state    <= HEADER;
              tx_valid <= 1'b1;
              tx_data  <= {trig_strb, 1'b0, pulse_ctr};
            end else begin
              state <= CAPTURE;
            end
          end
        end

        DELAY: begin
          if (!run) begin
            state    <= IDLE;
            trig_rdy <= 1'b1;
          end else if (dly_cnt == 8'd1) begin
            if (len_q == 7'd0) begin
              state    <= HEADER;
              tx_valid <= 1'b1;
              tx_data  <= {strb_q, 1'b0, pulse_q};
            end else begin
              state <= CAPTURE;
            end
          end else begin
            dly_cnt <= dly_cnt - 8'd1;
          end
        end

        CAPTURE: begin
          if (!run) begin
            state    <= IDLE;
            trig_rdy <= 1'b1;
          end else if (wr_idx == (len_q - 7'd1)) begin
            state    <= HEADER;
            tx_valid <= 1'b1;
            tx_data  <= {strb_q, 1'b0, pulse_q};
          end else begin
            wr_idx <= wr_idx + 7'd1;
          end
        end

        HEADER, DRAIN: begin
          if (!tx_valid) begin
            if (!run) begin
              state    <= IDLE;
              trig_rdy <= 1'b1;
            end
          end else if (xfer) begin
            byte_cnt <= byte_cnt + 8'd1;
            if (!run || (byte_cnt == last_byte)) begin
              // Either the packet is complete or readout was disabled; the
              // byte just accepted is the last one.
              state    <= IDLE;
              trig_rdy <= 1'b1;
              tx_valid <= 1'b0;
            end else begin
              state <= DRAIN;
              if (!byte_cnt[0]) begin
                // Next byte index is odd: high nibble of the prefetched sample.
                tx_data <= {4'h0, rd_q[11:8]};
                lo_hold <= rd_q[7:0];
                rd_idx  <= rd_idx + 7'd1;
              end else begin
                tx_data <= lo_hold;
              end
            end
          end
        end

        default: begin
          state    <= IDLE;
          trig_rdy <= 1'b1;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_daq_readout_ctrl.sv
// -----------------------------------------------------------------------------
// tb_daq_readout_ctrl
//
// Drives random ADC samples every cycle and logs them by cycle number. The
// expected packet is built from that log: header from the trigger settings,
// then the samples seen from cycle N+1+delay onward, split into high/low
// bytes. Inputs change on the falling edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_daq_readout_ctrl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        run = 1'b0;
  logic        trig_out = 1'b0;
  logic        trig_strb = 1'b0;
  logic [5:0]  pulse_ctr = '0;
  logic [7:0]  capture_delay = '0;
  logic [6:0]  sample_len = '0;
  logic [11:0] adc_data = '0;
  logic        ovr_clr = 1'b0;
  logic        tx_ready = 1'b0;
  logic        trig_rdy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        overrun;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  logic [11:0] hist [int];       // adc_data driven in each cycle
  logic [11:0] adc_force [$];    // directed samples, used once armed
  bit          arm = 1'b0;
  logic [7:0]  rxq [$];          // bytes observed on the tx interface
  logic [7:0]  exp_q [$];        // bytes the packet should contain

  logic [7:0]  golden45 [7] = '{8'h85, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF};

  daq_readout_ctrl #(.DATA_W(12), .DEPTH(64)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .run           (run),
    .trig_out      (trig_out),
    .trig_strb     (trig_strb),
    .pulse_ctr     (pulse_ctr),
    .capture_delay (capture_delay),
    .sample_len    (sample_len),
    .adc_data      (adc_data),
    .ovr_clr       (ovr_clr),
    .trig_rdy      (trig_rdy),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Move to the next falling edge and present a new ADC sample.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (arm && adc_force.size() > 0) adc_data = adc_force.pop_front();
    else                             adc_data = 12'($urandom);
    hist[cyc] = adc_data;
  endtask

  task automatic fire(input int dly, input int len, input logic [5:0] pc, input logic strb);
    run           = 1'b1;
    trig_out      = 1'b1;
    trig_strb     = strb;
    pulse_ctr     = pc;
    capture_delay = 8'(dly);
    sample_len    = 7'(len);
  endtask

  task automatic build_expected(input int n, input int dly, input int len_req,
                                input logic [5:0] pc, input logic strb);
    int          len;
    logic [11:0] s;
    len = (len_req > 64) ? 64 : len_req;
    exp_q.delete();
    exp_q.push_back({strb, 1'b0, pc});
    for (int i = 0; i < len; i++) begin
      s = hist[n + 1 + dly + i];
      exp_q.push_back({4'h0, s[11:8]});
      exp_q.push_back(s[7:0]);
    end
  endtask

  // One full packet. rmode: 0 ready always, 1 ready toggling, 2 ready random.
  // ovr_test injects a second trigger (with a simultaneous clear) in CAPTURE.
  task automatic do_packet(input int dly, input int len, input logic [5:0] pc,
                           input logic strb, input int rmode, input bit ovr_test);
    int         n;
    int         last_x;
    int         ovr_cyc;
    logic       stalled;
    logic [7:0] held;
    arm = 1'b0;
    tick();
    check("idle_rdy", 32'(trig_rdy), 32'd1);
    if (ovr_test) check("ovr_pre", 32'(overrun), 32'd0);
    fire(dly, len, pc, strb);
    n = cyc;
    arm = 1'b1;
    rxq.delete();
    stalled = 1'b0;
    held = '0;
    last_x = -100;
    ovr_cyc = n + dly + 2;
    for (int budget = 0; budget < 2000; budget++) begin
      tick();
      trig_out = 1'b0;
      ovr_clr  = 1'b0;
      if (cyc == n + 1) check("rdy_low", 32'(trig_rdy), 32'd0);
      if (trig_rdy) break;
      if (ovr_test && cyc == ovr_cyc) begin
        trig_out  = 1'b1;
        ovr_clr   = 1'b1;
        pulse_ctr = ~pc;
        trig_strb = ~strb;
      end
      if (ovr_test && cyc == ovr_cyc + 1) check("ovr_set", 32'(overrun), 32'd1);
      if (stalled) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(held));
      end
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 2 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (tx_valid && tx_ready) begin
        rxq.push_back(tx_data);
        last_x = cyc;
      end
      stalled = tx_valid && !tx_ready;
      held    = tx_data;
    end
    check("pkt_done", 32'(trig_rdy), 32'd1);
    check("rdy_after_last", 32'(cyc), 32'(last_x + 1));
    check("idle_valid", 32'(tx_valid), 32'd0);
    build_expected(n, dly, len, pc, strb);
    check("pkt_len", 32'(rxq.size()), 32'(exp_q.size()));
    for (int i = 0; i < rxq.size() && i < exp_q.size(); i++)
      check($sformatf("pkt_byte%0d", i), 32'(rxq[i]), 32'(exp_q[i]));
    if (ovr_test) begin
      check("ovr_sticky", 32'(overrun), 32'd1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'd0);
    end
  endtask

  // Drop run two cycles after the trigger (inside DELAY or CAPTURE).
  task automatic abort_early(input int dly);
    tick();
    fire(dly, 5, 6'h11, 1'b1);
    tx_ready = 1'b1;
    tick();
    trig_out = 1'b0;
    tick();
    run = 1'b0;
    tick();
    check("abort_rdy", 32'(trig_rdy), 32'd1);
    check("abort_novalid", 32'(tx_valid), 32'd0);
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_quiet", 32'(tx_valid), 32'd0);
    end
  endtask

  // Drop run while the third byte is stalled; it must still go out, then idle.
  task automatic abort_drain();
    int          n;
    logic [11:0] s;
    logic [7:0]  b2;
    arm = 1'b0;
    tick();
    fire(0, 3, 6'h2A, 1'b0);
    n = cyc;
    tx_ready = 1'b1;
    rxq.delete();
    for (int k = 0; k < 50 && rxq.size() < 2; k++) begin
      tick();
      trig_out = 1'b0;
      if (tx_valid && tx_ready) rxq.push_back(tx_data);
    end
    check("drn_pre_bytes", 32'(rxq.size()), 32'd2);
    s  = hist[n + 1];
    b2 = s[7:0];
    tick();
    run      = 1'b0;
    tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("drn_hold_valid", 32'(tx_valid), 32'd1);
      check("drn_hold_data", 32'(tx_data), 32'(b2));
      check("drn_busy", 32'(trig_rdy), 32'd0);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("drn_idle_rdy", 32'(trig_rdy), 32'd1);
    check("drn_idle_valid", 32'(tx_valid), 32'd0);
    run = 1'b1;
  endtask

  task automatic reset_mid_drain();
    tick();
    fire(0, 4, 6'h15, 1'b1);
    tx_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      trig_out = 1'b0;
    end
    check("rst_pre_valid", 32'(tx_valid), 32'd1);
    check("rst_pre_busy", 32'(trig_rdy), 32'd0);
    #2 rst_b = 1'b0;
    #1;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_rdy", 32'(trig_rdy), 32'd1);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    tick();
    rst_b = 1'b1;
    tick();
    check("post_rst_rdy", 32'(trig_rdy), 32'd1);
    check("post_rst_valid", 32'(tx_valid), 32'd0);
  endtask

  initial begin
    repeat (2) tick();
    check("reset_rdy", 32'(trig_rdy), 32'd1);
    check("reset_valid", 32'(tx_valid), 32'd0);
    check("reset_data", 32'(tx_data), 32'd0);
    check("reset_ovr", 32'(overrun), 32'd0);
    rst_b = 1'b1;
    run   = 1'b1;

    // Fixed three-sample packet with known bytes.
    adc_force = '{12'hABC, 12'h123, 12'hFFF};
    do_packet(0, 3, 6'd5, 1'b1, 0, 1'b0);
    check("d45_len", 32'(rxq.size()), 32'd7);
    for (int i = 0; i < rxq.size() && i < 7; i++)
      check("d45_byte", 32'(rxq[i]), 32'(golden45[i]));

    do_packet(4, 1, 6'h0C, 1'b0, 0, 1'b0);      // delayed single sample
    do_packet(0, 3, 6'h21, 1'b1, 1, 1'b0);      // tx_ready toggling
    do_packet(2, 6, 6'h33, 1'b1, 2, 1'b1);      // overrun during CAPTURE

    do_packet(0, 0, 6'd63, 1'b0, 0, 1'b0);      // header only
    check("len0_byte", 32'(rxq.size() > 0 ? rxq[0] : 8'h00), 32'h3F);

    // Trigger with run low in IDLE is ignored.
    tick();
    run      = 1'b0;
    trig_out = 1'b1;
    tick();
    trig_out = 1'b0;
    check("norun_rdy", 32'(trig_rdy), 32'd1);
    check("norun_ovr", 32'(overrun), 32'd0);
    tick();
    check("norun_valid", 32'(tx_valid), 32'd0);
    run = 1'b1;

    abort_early(10);                            // run low in DELAY
    abort_early(0);                             // run low in CAPTURE
    abort_drain();
    reset_mid_drain();

    do_packet(1, 100, 6'h2B, 1'b1, 0, 1'b0);    // clamps to 64 samples

    for (int r = 0; r < 8; r++) begin
      int len_r;
      len_r = int'($urandom_range(0, 70));
      do_packet(int'($urandom_range(0, 6)), len_r, 6'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), (len_r >= 2) && 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/daq_readout_ctrl.md
DAQ_READOUT_CTRL -- requirements
Module: daq_readout_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, 12, ADC sample width (fixed at 12 for the byte packing below).
REQ-002 The block SHALL have parameter DEPTH, 64, capture buffer depth in samples.
REQ-003 The block SHALL have port clk  input  1  single clock; every register is on posedge clk.
REQ-004 The block SHALL have port rst_b  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port run  input  1  enable, synchronous to clk.
REQ-006 The block SHALL have port trig_out  input  1  one-cycle trigger pulse from the trigger divider.
REQ-007 The block SHALL have port trig_strb  input  1  one-cycle strobe marking a real-data trigger; coincident with trig_out.
REQ-008 The block SHALL have port pulse_ctr  input  6  pulse count from the trigger divider.
REQ-009 The block SHALL have port capture_delay  input  8  cycles from trigger to first sample.
REQ-010 The block SHALL have port sample_len  input  7  samples per capture; valid range 0..64; values above 64 are clamped to 64.
REQ-011 The block SHALL have port adc_data  input  12  sample bus, sampled every cycle.
REQ-012 The block SHALL have port ovr_clr  input  1  clears the overrun flag.
REQ-013 The block SHALL have port trig_rdy  output  1  high only when idle and ready for the next trigger.
REQ-014 The block SHALL have port tx_data  output  8  readout byte.
REQ-015 The block SHALL have port tx_valid  output  1  tx_data valid.
REQ-016 The block SHALL have port tx_ready  input  1  sink accepts the byte.
REQ-017 The block SHALL have port overrun  output  1  sticky flag: a trigger arrived while busy.

Function
REQ-018 The state machine SHALL have the states IDLE, DELAY, CAPTURE, HEADER, DRAIN.
REQ-019 trig_rdy SHALL be a register equal to 1 exactly when the state is IDLE; its rising edge is the unblock event for the trigger divider.
REQ-020 In IDLE with run=1 and trig_out=1 at cycle N, the block SHALL latch capture_delay, clamped sample_len, pulse_ctr and trig_strb, and SHALL drive trig_rdy=0 at N+1.
REQ-021 After the trigger of REQ-020, the state SHALL be DELAY at N+1 if capture_delay>0, otherwise CAPTURE at N+1.
REQ-022 In DELAY, a counter SHALL run for capture_delay cycles and then move to CAPTURE.
REQ-023 In CAPTURE, adc_data SHALL be written to the buffer on consecutive cycles at addresses 0..len-1, then the state SHALL move to HEADER.
REQ-024 If len=0, the block SHALL skip CAPTURE and enter HEADER directly.
REQ-025 In HEADER, the block SHALL send the single byte {strb_latched, 1'b0, pulse_ctr_latched}.
REQ-026 In DRAIN, the block SHALL send 2 bytes per sample, address 0 first: {4'h0, d[11:8]} then d[7:0].
REQ-027 After the last byte transfers, the state SHALL return to IDLE.
REQ-028 A byte SHALL transfer on a cycle where tx_valid=1 and tx_ready=1.
REQ-029 Once tx_valid is asserted, tx_valid and tx_data SHALL stay stable until the byte transfers.
REQ-030 tx_valid SHALL stay stable until transfer when tx_ready is low.
REQ-031 Back-to-back transfers SHALL sustain 1 byte per cycle while tx_ready=1.
REQ-032 Buffer read latency SHALL be hidden by prefetching, so there are no bubbles.
REQ-033 If trig_out=1 while the state is not IDLE, overrun SHALL be set to 1 at the next cycle and the trigger SHALL be ignored.
REQ-034 overrun SHALL be cleared by ovr_clr=1.
REQ-035 If a set and a clear of overrun occur in the same cycle, set SHALL win.
REQ-036 If run=0 in DELAY or CAPTURE, the state SHALL return to IDLE next cycle with no bytes sent.
REQ-037 If run=0 in HEADER or DRAIN, the byte in flight SHALL complete, then the state SHALL go to IDLE.
REQ-038 If run=0 in HEADER or DRAIN and no byte is pending (tx_valid=0), the state SHALL go to IDLE next cycle.
REQ-039 In IDLE with run=0, triggers SHALL be ignored and SHALL NOT set overrun.
REQ-040 Counters SHALL be 8 bits (delay) and 7 bits (sample index); the byte counter SHALL be 8 bits with no wrap; the maximum packet is 129 bytes.

Reset
REQ-041 rst_b=0 SHALL asynchronously force state=IDLE, trig_rdy=1, tx_valid=0, tx_data=0, overrun=0, and all counters and latches to 0.
REQ-042 Buffer contents SHALL NOT be reset.
REQ-043 Reset asserted mid-transfer SHALL drop tx_valid immediately.
REQ-044 After rst_b is released, the first trigger SHALL be accepted no earlier than the first clk edge after release.

Verification
REQ-045 The bench SHALL cover: run=1, delay=0, len=3, samples 0xABC/0x123/0xFFF, pulse_ctr=5, strb=1, tx_ready=1 -> bytes 0x85,0x0A,0xBC,0x01,0x23,0x0F,0xFF; trig_rdy low from N+1 and high again one cycle after the last transfer.
REQ-046 The bench SHALL cover: delay=4, len=1 -> the sample written is adc_data at cycle N+5; the packet is 3 bytes.
REQ-047 The bench SHALL cover: tx_ready toggling 1/0 every cycle -> tx_data stable while stalled, no byte lost or duplicated, 7 bytes total for len=3.
REQ-048 The bench SHALL cover: second trig_out during CAPTURE -> overrun=1 next cycle; the packet is unchanged; ovr_clr clears it.
REQ-049 The bench SHALL cover: len=0, strb=0, pulse_ctr=63 -> single byte 0x3F, then IDLE.
REQ-050 The bench SHALL cover: run=0 mid-DRAIN with tx_ready=0 -> tx_valid held until tx_ready=1, then IDLE with trig_rdy=1; rst_b pulse mid-DRAIN -> tx_valid=0 and trig_rdy=1 immediately.
